multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the CPU datapath. It replaces single-cycle opcode decoding with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- One shared memory port carries both instruction fetch and data access, using a req/ready handshake with a timeout.
- Sits between the instruction register (opcode input) and the datapath mux/enable controls.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus_error; counter width is clog2(MEM_TIMEOUT+1).

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR, sampled in DECODE
- mem_ready  in  1  memory completes the access on this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct field, 11 opcode-decoded immediate
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- illegal_op  out  1  one-cycle pulse on undefined opcode
- bus_error  out  1  sticky; set on memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: R 000000, BEQ 000001, LW 000010, SW 000011, ADDI 000100, ANDI 000101, XORI 000110, SLTI 000111, J 001000, JAL 001001.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, I_EXEC, ALU_WB, BRANCH, JUMP, ERROR.
- All outputs are decoded from the registered state only (Moore). Any signal not listed for a state is 0.
- Reset: state=IDLE, counter=0, bus_error=0, illegal_op=0; all outputs 0. Reset asserted mid-instruction aborts it immediately, with no further writes.
- IDLE: outputs 0; next cycle goes to FETCH.
- FETCH:
  - Asserts mem_req, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - Waits while !mem_ready.
  - On mem_ready, ir_write=1 and pc_write=1 (pc_source=00) in that same cycle, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R -> R_EXEC
  - ADDI/ANDI/XORI/SLTI -> I_EXEC
  - BEQ -> BRANCH
  - J/JAL -> JUMP
  - other -> FETCH, with illegal_op pulsing during this DECODE cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_req=1, iord=1; holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; holds until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> ALU_WB.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI, 11 for ANDI/XORI/SLTI; -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00. reg_dst=01 for R, 00 for immediates. -> FETCH.
- Opcode latch: the opcode is latched in DECODE into an internal register. Later states use the latched value, not the live input.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH.
- JUMP: pc_write=1, pc_source=10. For JAL, also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4). -> FETCH.
- Timeout counter:
  - Clears on entry to any mem_req state; increments each cycle mem_req=1 && !mem_ready.
  - Reaching MEM_TIMEOUT sets bus_error and moves to ERROR.
- ERROR: all outputs 0; remains there until rst_n is asserted.
- mem_ready outside a mem_req state is ignored.
- Cycle counts with zero-wait memory:
  - LW 5 cycles (FETCH..MEM_WB).
  - SW, R-type and immediates 4 each.
  - BEQ, J and JAL 3 each.
  - Each memory wait cycle adds 1.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams
  - state enum typedef
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg encodings (shared with datapath and ALU decoder)
- Sub-module mem_timeout_ctr: the counter plus compare, with inputs clear, count_en and output expired.

Test Plan:
- Reset, then release with mem_ready=1 constantly -> IDLE, then FETCH one cycle later; ir_write and pc_write pulse in FETCH; state_dbg follows FETCH, DECODE.
- LW (000010), mem_ready delayed 3 cycles in MEM_RD -> mem_req, iord=1 held for 4 cycles; then MEM_WB with reg_write=1, mem_to_reg=01, reg_dst=00. Total 8 cycles.
- ANDI (000101) then R-type -> alu_op=11, reg_dst=00 in I_EXEC/ALU_WB; then alu_op=10, reg_dst=01. Opcode changes after DECODE have no effect.
- JAL (001001) -> JUMP cycle: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Back to FETCH after 3 cycles total.
- Opcode 111111 -> illegal_op high for exactly the DECODE cycle, with no reg_write, mem_we or pc write; next state FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> bus_error=1 after 16 wait cycles, state ERROR, all outputs 0; rst_n low clears bus_error asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer, the datapath muxes and the ALU decoder.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b000010;
    localparam logic [5:0] OP_SW   = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_ANDI = 6'b000101;
    localparam logic [5:0] OP_XORI = 6'b000110;
    localparam logic [5:0] OP_SLTI = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b001001;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ERROR    = 4'd12
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the shared memory port; flags expiry on the wait that reaches the limit.
module mem_timeout_ctr
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned    CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0]  ONE   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is independent of clear so the FSM can use it to choose its next state.
    assign expired = count_en && (cnt_q >= (LIMIT - ONE));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control sequencer stepping each instruction through fetch/decode/execute/memory/writeback.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       bus_err_q, bus_err_d;
    logic       expired_s, clear_s, count_en_s;

    // State, latched opcode and sticky bus error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 6'b000000;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Opcode capture and sticky error update.
    always_comb begin
        if (state_q == ST_DECODE) begin
            op_d = opcode;
        end else begin
            op_d = op_q;
        end
        bus_err_d = bus_err_q | expired_s;
    end

    assign count_en_s = is_mem_state(state_q) && !mem_ready;
    assign clear_s    = (state_d != state_q);

    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_s),
        .count_en (count_en_s),
        .expired  (expired_s)
    );

    // Next-state logic; DECODE uses the live opcode, later states the latched copy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    state_d = expired_s ? ST_ERROR : (mem_ready ? ST_DECODE : ST_FETCH);
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_R:                             state_d = ST_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = ST_I_EXEC;
                    OP_BEQ:                           state_d = ST_BRANCH;
                    OP_J, OP_JAL:                     state_d = ST_JUMP;
                    default:                          state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = expired_s ? ST_ERROR : (mem_ready ? ST_MEM_WB : ST_MEM_RD);
            ST_MEM_WR:   state_d = expired_s ? ST_ERROR : (mem_ready ? ST_FETCH : ST_MEM_WR);
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_R_EXEC:   state_d = ST_ALU_WB;
            ST_I_EXEC:   state_d = ST_ALU_WB;
            ST_ALU_WB:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_ERROR:    state_d = ST_ERROR;
            default:     state_d = ST_ERROR;
        endcase
    end

    // Datapath controls decoded from the registered state.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_R, OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_ANDI,
                    OP_XORI, OP_SLTI, OP_J, OP_JAL: illegal_op = 1'b0;
                    default:                        illegal_op = 1'b1;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (op_q == OP_ADDI) ? ALU_ADD : ALU_IMM;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op_q == OP_R) ? REGDST_RD : REGDST_RT;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_R31;
                    mem_to_reg = M2R_PC;
                end else begin
                    reg_write  = 1'b0;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign bus_error = bus_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle state and control vectors against hand-written values.
module tb_multicycle_ctrl_fsm;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7;
    localparam logic [3:0] S_I_EXEC = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_ERROR = 4'd12;

    localparam logic [5:0] O_R = 6'b000000, O_BEQ = 6'b000001, O_LW = 6'b000010, O_SW = 6'b000011;
    localparam logic [5:0] O_ANDI = 6'b000101, O_JAL = 6'b001001, O_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_write, illegal_op, bus_error;
    logic [3:0] state_dbg;
    logic [19:0] ctl_s;

    int n_cmp = 0;
    int n_mis = 0;

    logic [19:0] c_zero, c_fetch_rdy, c_fetch_wait, c_decode, c_decode_ill, c_mem_addr;
    logic [19:0] c_mem_rd, c_mem_wb, c_mem_wr, c_r_exec, c_i_exec_imm, c_alu_wb_i;
    logic [19:0] c_alu_wb_r, c_jal, c_beq, c_err;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal_op    (illegal_op),
        .bus_error     (bus_error),
        .state_dbg     (state_dbg)
    );

    assign ctl_s = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                    alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                    illegal_op, bus_error};

    function automatic logic [19:0] mk(input logic req, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic pcc,
                                       input logic [1:0] pcs, input logic a, input logic [1:0] b,
                                       input logic [1:0] op, input logic rw, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic ill, input logic be);
        return {req, we, io, irw, pcw, pcc, pcs, a, b, op, rw, rd, m2r, ill, be};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, check the current cycle, advance one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [5:0] opc,
                       input logic [3:0] st, input logic [19:0] ctl);
        mem_ready = rdy;
        opcode    = opc;
        #1;
        check_val({tag, ".state"}, 32'(state_dbg), 32'(st));
        check_val({tag, ".ctl"}, 32'(ctl_s), 32'(ctl));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                  req we io irw pcw pcc pcs   a  b      op     rw rd     m2r  ill be
        c_zero       = 20'h00000;
        c_fetch_rdy  = mk(1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_fetch_wait = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_decode     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_decode_ill = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 1, 0);
        c_mem_addr   = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_mem_rd     = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_mem_wb     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0, 0);
        c_mem_wr     = mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
        c_r_exec     = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 2'b00, 2'b00, 0, 0);
        c_i_exec_imm = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b11, 0, 2'b00, 2'b00, 0, 0);
        c_alu_wb_i   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0);
        c_alu_wb_r   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 0, 0);
        c_jal        = mk(0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 1, 2'b10, 2'b10, 0, 0);
        c_beq        = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 0);
        c_err        = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1);

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = O_R;
        repeat (2) @(negedge clk);
        cyc("reset", 1'b1, O_R, S_IDLE, c_zero);
        rst_n = 1'b1;
        cyc("idle", 1'b1, O_R, S_IDLE, c_zero);

        // LW with three wait cycles in MEM_RD: eight cycles FETCH..MEM_WB.
        cyc("lw.fetch", 1'b1, O_LW, S_FETCH, c_fetch_rdy);
        cyc("lw.decode", 1'b1, O_LW, S_DECODE, c_decode);
        cyc("lw.addr", 1'b1, O_LW, S_MEM_ADDR, c_mem_addr);
        for (int i = 0; i < 3; i++) cyc("lw.rd_wait", 1'b0, O_LW, S_MEM_RD, c_mem_rd);
        cyc("lw.rd_done", 1'b1, O_LW, S_MEM_RD, c_mem_rd);
        cyc("lw.wb", 1'b1, O_LW, S_MEM_WB, c_mem_wb);

        cyc("ill.fetch", 1'b1, O_BAD, S_FETCH, c_fetch_rdy);
        cyc("ill.decode", 1'b1, O_BAD, S_DECODE, c_decode_ill);

        // Live opcode is changed after DECODE to show the latched copy is used.
        cyc("andi.fetch", 1'b1, O_ANDI, S_FETCH, c_fetch_rdy);
        cyc("andi.decode", 1'b1, O_ANDI, S_DECODE, c_decode);
        cyc("andi.exec", 1'b1, O_R, S_I_EXEC, c_i_exec_imm);
        cyc("andi.wb", 1'b1, O_R, S_ALU_WB, c_alu_wb_i);

        cyc("r.fetch", 1'b1, O_R, S_FETCH, c_fetch_rdy);
        cyc("r.decode", 1'b1, O_R, S_DECODE, c_decode);
        cyc("r.exec", 1'b1, O_ANDI, S_R_EXEC, c_r_exec);
        cyc("r.wb", 1'b1, O_ANDI, S_ALU_WB, c_alu_wb_r);

        cyc("jal.fetch", 1'b1, O_JAL, S_FETCH, c_fetch_rdy);
        cyc("jal.decode", 1'b1, O_JAL, S_DECODE, c_decode);
        cyc("jal.jump", 1'b1, O_R, S_JUMP, c_jal);

        cyc("beq.fetch", 1'b1, O_BEQ, S_FETCH, c_fetch_rdy);
        cyc("beq.decode", 1'b1, O_BEQ, S_DECODE, c_decode);
        cyc("beq.branch", 1'b1, O_R, S_BRANCH, c_beq);

        cyc("sw.fetch", 1'b1, O_SW, S_FETCH, c_fetch_rdy);
        cyc("sw.decode", 1'b1, O_SW, S_DECODE, c_decode);
        cyc("sw.addr", 1'b1, O_LW, S_MEM_ADDR, c_mem_addr);
        cyc("sw.wr", 1'b1, O_LW, S_MEM_WR, c_mem_wr);

        // Fetch never completes: the 16th wait cycle moves to ERROR.
        for (int i = 0; i < 16; i++) cyc("to.wait", 1'b0, O_R, S_FETCH, c_fetch_wait);
        cyc("to.error", 1'b0, O_R, S_ERROR, c_err);
        cyc("to.hold", 1'b1, O_R, S_ERROR, c_err);

        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst.state", 32'(state_dbg), 32'(S_IDLE));
        check_val("arst.ctl", 32'(ctl_s), 32'(c_zero));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
